killer_sweep_ctrl: RTL and testbench

KILLER_SWEEP_CTRL -- requirements
Module: killer_sweep_ctrl

---
 rtl/killer_pkg.sv | 20 ++
 rtl/killer_func.sv | 11 +
 rtl/killer_sweep_ctrl.sv | 115 +++++++++++
 tb/tb_killer_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/killer_pkg.sv
// Shared constants for the killer-function sweep controller: state encoding,
// vector geometry and the MISR step used when KILLER_SWEEP_MISR_EN is defined.
package killer_pkg;

    localparam int VEC_W    = 6;
    localparam int NUM_VEC  = 64;
    localparam int HOLD_MAX = 15;

    localparam logic [7:0] MISR_POLY = 8'h1D;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic bit_in);
        return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {7'b0, bit_in};
    endfunction

endpackage

// File: rtl/killer_func.sv
// Combinational six-input logic function under test.
module killer_func
    import killer_pkg::*;
(
    input  logic [VEC_W-1:0] x,
    output logic             f
);

    assign f = (x[0] & ~x[5]) | (~x[4] & ~x[5]) | (x[2] & ~x[5]) | (x[3] & x[4] & x[5]);

endmodule

// File: rtl/killer_sweep_ctrl.sv
// Exhaustive 64-vector sweep of killer_func with hold/sample timing, ones count
// and an optional MISR signature (enabled by defining KILLER_SWEEP_MISR_EN).
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep are held
// APPLY  | vec_out driven, held for HOLD cycles
// SAMPLE | f captured, ones_cnt and signature updated, next vector chosen
// DONE   | last vector sampled; done pulses on the way back to IDLE
module killer_sweep_ctrl
    import killer_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec_out,
    output logic             f_out,
    output logic             busy,
    output logic             done,
    output logic [6:0]       ones_cnt,
    output logic [7:0]       signature
);

    localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
    localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VEC - 1);

    logic [1:0] state;
    logic [3:0] hold_cnt;
    logic       f_cur;
    logic       sweep_go;
    logic       sample_en;

    killer_func u_func (
        .x (vec_out),
        .f (f_cur)
    );

    assign busy      = (state != ST_IDLE);
    assign sweep_go  = (state == ST_IDLE) && start && !abort;
    assign sample_en = (state == ST_SAMPLE) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            vec_out  <= '0;
            f_out    <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sweep_go) begin
                        state    <= ST_APPLY;
                        vec_out  <= '0;
                        ones_cnt <= '0;
                        hold_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    // An abort here drops the pending sample so results cover whole vectors only
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        f_out    <= f_cur;
                        ones_cnt <= ones_cnt + {6'b0, f_cur};
                        if (vec_out == VEC_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                            state   <= ST_APPLY;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KILLER_SWEEP_MISR_EN
    logic [7:0] sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else if (sweep_go) begin
            sig_q <= '0;
        end else if (sample_en) begin
            sig_q <= misr_next(sig_q, f_cur);
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_killer_sweep_ctrl.sv
// Scoreboard bench for killer_sweep_ctrl: randomized sweeps, aborts, stray starts
// and mid-sweep resets checked against an arithmetic model of the sweep.
module tb_killer_sweep_ctrl;

    localparam int HOLD      = 2;
    localparam int SWEEP_LEN = 1 + 64 * (HOLD + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] vec_out;
    logic       f_out;
    logic       busy;
    logic       done;
    logic [6:0] ones_cnt;
    logic [7:0] signature;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         exp_done;
        int         exp_len;
        logic [5:0] vec;
        logic [6:0] ones;
        logic [7:0] sig;
        logic       fo;
    } exp_t;

    exp_t sb_q[$];
    logic model_fo;

    killer_sweep_ctrl #(.HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .vec_out   (vec_out),
        .f_out     (f_out),
        .busy      (busy),
        .done      (done),
        .ones_cnt  (ones_cnt),
        .signature (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_f(input int v);
        logic [5:0] x;
        x = v[5:0];
        return (x[0] & ~x[5]) | (~x[4] & ~x[5]) | (x[2] & ~x[5]) | (x[3] & x[4] & x[5]);
    endfunction

    function automatic int ref_ones(input int n);
        int c = 0;
        for (int v = 0; v < n; v++) c += int'(ref_f(v));
        return c;
    endfunction

    function automatic logic [7:0] ref_sig(input int n);
        int s = 0;
`ifdef KILLER_SWEEP_MISR_EN
        for (int v = 0; v < n; v++) begin
            s = ((s << 1) & 8'hFF) ^ (((s >> 7) & 1) != 0 ? 8'h1D : 0) ^ int'(ref_f(v));
        end
`endif
        return 8'(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: per-vector f_out check and end-of-sweep scoreboard pop
    initial begin
        logic       prev_busy = 1'b0;
        logic [5:0] prev_vec  = '0;
        int         start_cyc = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) start_cyc = cyc;
                if (busy) check("done_while_busy", 32'(done), 32'd0);
                if (busy && prev_busy && int'(vec_out) == int'(prev_vec) + 1)
                    check("f_out_vec", 32'(f_out), 32'(ref_f(int'(prev_vec))));
                if (prev_busy && !busy) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: sweep ended with no expectation queued");
                    end else begin
                        e = sb_q.pop_front();
                        check("sweep_len", 32'(cyc - start_cyc), 32'(e.exp_len));
                        check("done_pulse", 32'(done), 32'(e.exp_done));
                        check("vec_out_end", 32'(vec_out), 32'(e.vec));
                        check("ones_cnt_end", 32'(ones_cnt), 32'(e.ones));
                        check("signature_end", 32'(signature), 32'(e.sig));
                        check("f_out_end", 32'(f_out), 32'(e.fo));
                    end
                end
                prev_busy = busy;
                prev_vec  = vec_out;
            end
        end
    end

    // k = 0: no abort; otherwise abort is effective on edge k after the start edge
    task automatic run_sweep(input int k, input bit mid_start, input int mid_at);
        exp_t e;
        int   n;
        if (k == 0 || k >= SWEEP_LEN) begin
            n          = 64;
            e.exp_done = 1'b1;
            e.exp_len  = SWEEP_LEN;
            e.vec      = 6'd63;
        end else begin
            n          = (k - 1) / (HOLD + 1);
            e.exp_done = 1'b0;
            e.exp_len  = k;
            e.vec      = 6'(n);
        end
        e.ones   = 7'(ref_ones(n));
        e.sig    = ref_sig(n);
        e.fo     = (n > 0) ? ref_f(n - 1) : model_fo;
        model_fo = e.fo;
        sb_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= SWEEP_LEN; j++) begin
            abort = (j == k);
            start = mid_start && (j == mid_at);
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
            if (!busy) break;
        end
        for (int t = 0; t < 400 && busy; t++) @(posedge clk);
        if (busy) check("sweep_timeout", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("start_abort_busy2", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid(input int wait_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (wait_cyc) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vec", 32'(vec_out), 32'd0);
        check("rst_f_out", 32'(f_out), 32'd0);
        check("rst_ones", 32'(ones_cnt), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        model_fo = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, mid, mid_at, hi;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        model_fo = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_vec", 32'(vec_out), 32'd0);
        check("reset_f_out", 32'(f_out), 32'd0);
        check("reset_ones", 32'(ones_cnt), 32'd0);
        check("reset_sig", 32'(signature), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_sweep(0, 1'b0, 0);
        run_sweep(10 * (HOLD + 1) + 1, 1'b0, 0);
        start_abort_idle();
        run_sweep(0, 1'b1, 50);
        reset_mid(int'($urandom_range(20, 150)));
        run_sweep(0, 1'b0, 0);
        run_sweep(SWEEP_LEN, 1'b0, 0);
        run_sweep(HOLD + 1, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            k   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, SWEEP_LEN));
            hi  = (k == 0) ? SWEEP_LEN - 1 : k - 1;
            mid = (hi >= 1) ? int'($urandom_range(0, 1)) : 0;
            mid_at = (mid != 0) ? int'($urandom_range(1, hi)) : 0;
            run_sweep(k, mid[0], mid_at);
            if ($urandom_range(0, 3) == 0) start_abort_idle();
        end

        repeat (5) @(posedge clk);
        #1 check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
